// File: rtl/ensemble_vote_ctrl.sv
// Ensemble vote controller: forks one host feature frame to three classifiers,
// collects one label per classifier under a timeout and emits a majority-vote beat.
module ensemble_vote_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = 4,
   parameter int LABEL_W    = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [3*DATA_WIDTH-1:0] m_cls_tdata,
   output logic [3*KEEP_WIDTH-1:0] m_cls_tkeep,
   output logic [2:0]              m_cls_tvalid,
   input  logic [2:0]              m_cls_tready,
   output logic [2:0]              m_cls_tlast,
   input  logic [3*DATA_WIDTH-1:0] s_cls_tdata,
   input  logic [2:0]              s_cls_tvalid,
   output logic [2:0]              s_cls_tready,
   input  logic [2:0]              s_cls_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    timeout_err
);

   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BCAST,
      S_COLLECT,
      S_VOTE,
      S_OUT
   } state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] hold_data;
   logic [KEEP_WIDTH-1:0] hold_keep;
   logic                  hold_last;
   logic                  hold_vld;
   logic [2:0]            pend;
   logic [2:0]            got;
   logic [2:0]            seen;
   logic [LABEL_W-1:0]    label_q [3];
   logic [TIMER_W-1:0]    timer;
   logic [LABEL_W-1:0]    vote_label;
   logic [1:0]            vote_cnt;
   logic                  vote_nq;

   logic                  host_hs;
   logic [2:0]            bcast_hs;
   logic [2:0]            pend_left;
   logic [2:0]            res_hs;
   logic [2:0]            got_upd;
   logic                  timer_hit;
   logic [LABEL_W-1:0]    win_label;
   logic [1:0]            win_cnt;

   // Only the label field of a result beat carries information.
   logic unused_res_msbs;
   assign unused_res_msbs = ^{s_cls_tdata[3*DATA_WIDTH-1:2*DATA_WIDTH+LABEL_W],
                              s_cls_tdata[2*DATA_WIDTH-1:DATA_WIDTH+LABEL_W],
                              s_cls_tdata[DATA_WIDTH-1:LABEL_W]};

   assign s_axis_tready = (state == S_BCAST) & ~hold_vld;
   assign host_hs       = s_axis_tvalid & s_axis_tready;

   // Each branch drops out of the fork independently; valid never waits on ready.
   assign m_cls_tvalid  = {3{hold_vld}} & pend;
   assign m_cls_tdata   = {3{hold_data}};
   assign m_cls_tkeep   = {3{hold_keep}};
   assign m_cls_tlast   = {3{hold_last}};
   assign bcast_hs      = m_cls_tvalid & m_cls_tready;
   assign pend_left     = pend & ~bcast_hs;

   assign s_cls_tready  = (state == S_COLLECT) ? ~got : 3'b000;
   assign res_hs        = s_cls_tvalid & s_cls_tready;
   assign got_upd       = got | (res_hs & s_cls_tlast);
   assign timer_hit     = (timer == TIMER_LAST);

   assign m_axis_tvalid = (state == S_OUT);
   assign m_axis_tkeep  = {KEEP_WIDTH{m_axis_tvalid}};
   assign m_axis_tlast  = m_axis_tvalid;

   always_comb begin
      m_axis_tdata = '0;
      if (state == S_OUT) begin
         m_axis_tdata[LABEL_W-1:0]     = vote_label;
         m_axis_tdata[LABEL_W +: 2]    = vote_cnt;
         m_axis_tdata[LABEL_W+2 +: 3]  = got;
         m_axis_tdata[DATA_WIDTH-1]    = vote_nq;
      end
   end

   // Pairs agree first; otherwise the lowest-index present classifier wins alone.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      win_label = '0;
      win_cnt   = 2'd0;
      if (&got && label_q[0] == label_q[1] && label_q[1] == label_q[2]) begin
         win_label = label_q[0];
         win_cnt   = 2'd3;
      end else if (got[0] && got[1] && label_q[0] == label_q[1]) begin
         win_label = label_q[0];
         win_cnt   = 2'd2;
      end else if (got[0] && got[2] && label_q[0] == label_q[2]) begin
         win_label = label_q[0];
         win_cnt   = 2'd2;
      end else if (got[1] && got[2] && label_q[1] == label_q[2]) begin
         win_label = label_q[1];
         win_cnt   = 2'd2;
      end else if (got[0]) begin
         win_label = label_q[0];
         win_cnt   = 2'd1;
      end else if (got[1]) begin
         win_label = label_q[1];
         win_cnt   = 2'd1;
      end else if (got[2]) begin
         win_label = label_q[2];
         win_cnt   = 2'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    state_nxt = S_BCAST;
         S_BCAST:   if (hold_vld && pend_left == 3'b000 && hold_last) state_nxt = S_COLLECT;
         S_COLLECT: if (got_upd == 3'b111 || timer_hit) state_nxt = S_VOTE;
         S_VOTE:    state_nxt = S_OUT;
         S_OUT:     if (m_axis_tready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset as well, so every output reads zero from reset onward.
         hold_data   <= '0;
         hold_keep   <= '0;
         hold_last   <= 1'b0;
         hold_vld    <= 1'b0;
         pend        <= 3'b000;
         got         <= 3'b000;
         seen        <= 3'b000;
         timer       <= '0;
         timeout_err <= 1'b0;
         vote_label  <= '0;
         vote_cnt    <= 2'd0;
         vote_nq     <= 1'b0;
         for (int k = 0; k < 3; k++) label_q[k] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               hold_vld <= 1'b0;
               pend     <= 3'b000;
               got      <= 3'b000;
               seen     <= 3'b000;
               timer    <= '0;
            end
            S_BCAST: begin
               timer <= '0;
               if (host_hs) begin
                  hold_data <= s_axis_tdata;
                  hold_keep <= s_axis_tkeep;
                  hold_last <= s_axis_tlast;
                  hold_vld  <= 1'b1;
                  pend      <= 3'b111;
               end else if (hold_vld) begin
                  pend <= pend_left;
                  if (pend_left == 3'b000) hold_vld <= 1'b0;
               end
            end
            S_COLLECT: begin
               timer <= timer + TIMER_W'(1);
               seen  <= seen | res_hs;
               got   <= got_upd;
               for (int k = 0; k < 3; k++) begin
                  if (res_hs[k] && !seen[k]) label_q[k] <= s_cls_tdata[k*DATA_WIDTH +: LABEL_W];
               end
               // A result landing on the final cycle still counts, so no error then.
               if (timer_hit && got_upd != 3'b111) timeout_err <= 1'b1;
            end
            S_VOTE: begin
               vote_label <= win_label;
               vote_cnt   <= win_cnt;
               vote_nq    <= (got == 3'b000);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ensemble_vote_ctrl.sv
// Scoreboard bench for ensemble_vote_ctrl: random frames and classifier behaviour,
// expected vote beats come from a counting reference model and are checked by a monitor.
module tb_ensemble_vote_ctrl;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int LW = 8;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [DW-1:0]   s_axis_tdata = '0;
   logic [KW-1:0]   s_axis_tkeep = '0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic            s_axis_tlast = 1'b0;
   logic [3*DW-1:0] m_cls_tdata;
   logic [3*KW-1:0] m_cls_tkeep;
   logic [2:0]      m_cls_tvalid;
   logic [2:0]      m_cls_tready = '0;
   logic [2:0]      m_cls_tlast;
   logic [3*DW-1:0] s_cls_tdata = '0;
   logic [2:0]      s_cls_tvalid = '0;
   logic [2:0]      s_cls_tready;
   logic [2:0]      s_cls_tlast = '0;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b0;
   logic            m_axis_tlast;
   logic            timeout_err;

   always #5 clk = ~clk;

   ensemble_vote_ctrl #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LABEL_W(LW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_cls_tdata(m_cls_tdata), .m_cls_tkeep(m_cls_tkeep), .m_cls_tvalid(m_cls_tvalid),
      .m_cls_tready(m_cls_tready), .m_cls_tlast(m_cls_tlast),
      .s_cls_tdata(s_cls_tdata), .s_cls_tvalid(s_cls_tvalid), .s_cls_tready(s_cls_tready),
      .s_cls_tlast(s_cls_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   // kind: 1 = latency measured from last result, 2 = vote forced by timeout
   typedef struct {
      logic [DW-1:0] data;
      int            kind;
   } exp_t;

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         last_bc_cyc = 0;
   int         last_res_cyc = 0;
   exp_t       exp_q[$];
   exp_t       mon_e;
   beat_t      rx_q[3][$];
   beat_t      res_q[3][$];
   int         stall_k1 = 0;
   bit         stall_all = 1'b0;
   bit         rand_ready = 1'b1;
   bit         hold_out = 1'b0;
   bit         chk_stall = 1'b0;
   logic [2:0] res_pend_hs = '0;
   bit         out_seen = 1'b0;
   bit         out_hs = 1'b0;
   logic [DW-1:0] out_held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: each present label's agreement count; the highest count wins, ties to lowest index.
   function automatic logic [DW-1:0] ref_vote(input logic [2:0] present, input logic [LW-1:0] lab [3]);
      logic [DW-1:0] r;
      int best;
      int best_k;
      int cnt;
      best = 0;
      best_k = -1;
      for (int k = 0; k < 3; k++) begin
         if (present[k]) begin
            cnt = 0;
            for (int j = 0; j < 3; j++) if (present[j] && lab[j] == lab[k]) cnt++;
            if (cnt > best) begin
               best = cnt;
               best_k = k;
            end
         end
      end
      r = '0;
      if (best_k >= 0) r[LW-1:0] = lab[best_k];
      r[LW +: 2]   = 2'(best);
      r[LW+2 +: 3] = present;
      r[DW-1]      = (present == 3'b000);
      return r;
   endfunction

   // Classifier agents: take broadcast beats, return queued result beats.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_cls_tready = '0;
         s_cls_tvalid = '0;
         s_cls_tlast  = '0;
         s_cls_tdata  = '0;
         res_pend_hs  = '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (stall_all || (k == 1 && stall_k1 > 0)) m_cls_tready[k] = 1'b0;
            else if (rand_ready)                       m_cls_tready[k] = ($urandom_range(0, 3) != 0);
            else                                       m_cls_tready[k] = 1'b1;
         end
         if (stall_k1 > 0 && m_cls_tvalid[1]) stall_k1--;
         for (int k = 0; k < 3; k++) begin
            if (m_cls_tvalid[k] && m_cls_tready[k]) begin
               rx_q[k].push_back('{m_cls_tdata[k*DW +: DW], m_cls_tkeep[k*KW +: KW], m_cls_tlast[k]});
               last_bc_cyc = cyc;
            end
         end
         if (chk_stall && m_cls_tvalid != 3'b000)
            check("host ready while beat held", 64'(s_axis_tready), 64'd0);
         for (int k = 0; k < 3; k++) begin
            if (res_pend_hs[k]) begin
               if (res_q[k].size() > 0) void'(res_q[k].pop_front());
               s_cls_tvalid[k] = 1'b0;
            end
            if (!s_cls_tvalid[k] && res_q[k].size() > 0 && $urandom_range(0, 2) != 0) begin
               s_cls_tvalid[k]          = 1'b1;
               s_cls_tdata[k*DW +: DW]  = res_q[k][0].data;
               s_cls_tlast[k]           = res_q[k][0].last;
            end
            res_pend_hs[k] = s_cls_tvalid[k] & s_cls_tready[k];
            if (res_pend_hs[k] && s_cls_tlast[k]) last_res_cyc = cyc;
         end
      end
   end

   // Monitor: compares each new vote beat against the scoreboard head.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_axis_tready = 1'b0;
         out_seen      = 1'b0;
         out_hs        = 1'b0;
      end else begin
         if (out_hs) out_seen = 1'b0;
         if (m_axis_tvalid) begin
            if (!out_seen) begin
               out_seen = 1'b1;
               out_held = m_axis_tdata;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected vote beat: got 0x%0h, expected none", m_axis_tdata);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("vote tdata", 64'(m_axis_tdata), 64'(mon_e.data));
                  check("vote tkeep", 64'(m_axis_tkeep), 64'({KW{1'b1}}));
                  check("vote tlast", 64'(m_axis_tlast), 64'd1);
                  if (mon_e.kind == 1)
                     check("latency from last result", 64'(cyc - last_res_cyc), 64'd2);
                  else
                     check("latency to timeout vote", 64'(cyc - last_bc_cyc), 64'(TO + 2));
               end
            end else begin
               check("vote beat held stable", 64'(m_axis_tdata), 64'(out_held));
            end
            m_axis_tready = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
         end else begin
            m_axis_tready = 1'b0;
         end
         out_hs = m_axis_tvalid & m_axis_tready;
      end
   end

   task automatic send_frame(input beat_t f[$]);
      int budget;
      foreach (f[i]) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = f[i].data;
         s_axis_tkeep  = f[i].keep;
         s_axis_tlast  = f[i].last;
         budget = 0;
         while (!s_axis_tready && budget < 2000) begin
            @(negedge clk);
            budget++;
         end
         if (!s_axis_tready) begin
            n_tests++;
            n_fail++;
            $display("FAIL host handshake: beat %0d not accepted, expected acceptance", i);
            s_axis_tvalid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic run_frame(input int nbeats, input logic [2:0] resp,
                            input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic [LW-1:0] l2);
      beat_t         frame[$];
      beat_t         b;
      logic [LW-1:0] labs [3];
      int            nres;
      int            budget;
      int            n;
      labs[0] = l0;
      labs[1] = l1;
      labs[2] = l2;
      for (int i = 0; i < nbeats; i++) begin
         b.data = $urandom;
         b.keep = KW'($urandom_range(1, 15));
         b.last = (i == nbeats - 1);
         frame.push_back(b);
      end
      for (int k = 0; k < 3; k++) begin
         if (resp[k]) begin
            nres = $urandom_range(1, 2);
            for (int j = 0; j < nres; j++) begin
               b.data = $urandom;
               if (j == 0) b.data[LW-1:0] = labs[k];
               b.keep = '0;
               b.last = (j == nres - 1);
               res_q[k].push_back(b);
            end
         end
      end
      exp_q.push_back('{ref_vote(resp, labs), (resp == 3'b111) ? 1 : 2});
      send_frame(frame);
      budget = 0;
      while (exp_q.size() != 0 && budget < 4 * TO + 400) begin
         @(negedge clk);
         budget++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL vote beat wait: %0d beats outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bcast beat count k%0d", k), 64'(rx_q[k].size()), 64'(nbeats));
         n = (rx_q[k].size() < nbeats) ? rx_q[k].size() : nbeats;
         for (int i = 0; i < n; i++) begin
            check($sformatf("bcast data k%0d b%0d", k, i), 64'(rx_q[k][i].data), 64'(frame[i].data));
            check($sformatf("bcast keep k%0d b%0d", k, i), 64'(rx_q[k][i].keep), 64'(frame[i].keep));
            check($sformatf("bcast last k%0d b%0d", k, i), 64'(rx_q[k][i].last), 64'(frame[i].last));
         end
         rx_q[k].delete();
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " s_axis_tready"}, 64'(s_axis_tready), 64'd0);
      check({tag, " m_cls_tvalid"},  64'(m_cls_tvalid), 64'd0);
      check({tag, " m_cls_tdata"},   64'(|m_cls_tdata), 64'd0);
      check({tag, " m_cls_tkeep/last"}, 64'({m_cls_tkeep, m_cls_tlast}), 64'd0);
      check({tag, " s_cls_tready"},  64'(s_cls_tready), 64'd0);
      check({tag, " m_axis_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, " m_axis_tdata"},  64'(m_axis_tdata), 64'd0);
      check({tag, " m_axis_tkeep/last"}, 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
      check({tag, " timeout_err"},   64'(timeout_err), 64'd0);
   endtask

   // Called at a negedge; reset lands mid-cycle, away from the active edge.
   task automatic apply_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero(tag);
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         rx_q[k].delete();
         res_q[k].delete();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      stall_all     = 1'b0;
      hold_out      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL global watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int budget;
      logic [2:0] resp;
      @(negedge clk);
      check_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      rand_ready = 1'b0;
      run_frame(3, 3'b111, 8'd5, 8'd5, 8'd5);
      run_frame(2, 3'b111, 8'd2, 8'd7, 8'd2);
      run_frame(1, 3'b111, 8'd1, 8'd2, 8'd3);

      stall_k1  = 10;
      chk_stall = 1'b1;
      run_frame(3, 3'b111, 8'd6, 8'd6, 8'd9);
      chk_stall = 1'b0;
      check("branch 1 stall consumed", 64'(stall_k1), 64'd0);
      check("timeout_err before timeout", 64'(timeout_err), 64'd0);

      run_frame(2, 3'b011, 8'd4, 8'd9, 8'd0);
      check("timeout_err sticky after timeout", 64'(timeout_err), 64'd1);
      run_frame(2, 3'b000, 8'd0, 8'd0, 8'd0);

      rand_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         resp = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 6));
         run_frame($urandom_range(1, 4), resp, 8'($urandom_range(0, 3)),
                   8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
      end
      check("timeout_err still sticky", 64'(timeout_err), 64'd1);

      // Reset with a beat held in the broadcast fork.
      @(negedge clk);
      stall_all     = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hA5A5_0001;
      s_axis_tkeep  = 4'hF;
      s_axis_tlast  = 1'b0;
      budget = 0;
      while (m_cls_tvalid == 3'b000 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      s_axis_tvalid = 1'b0;
      check("bcast held before reset", 64'(m_cls_tvalid), 64'd7);
      apply_reset("reset mid-bcast");
      run_frame(2, 3'b111, 8'd3, 8'd1, 8'd1);

      // Reset while the vote beat is stalled downstream.
      hold_out = 1'b1;
      run_frame(1, 3'b111, 8'd7, 8'd7, 8'd7);
      check("vote beat pending before reset", 64'(m_axis_tvalid), 64'd1);
      apply_reset("reset mid-out");
      run_frame(3, 3'b111, 8'd2, 8'd0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
